alu_exec: RTL and testbench

Execute stage of the datapath, directly downstream of the register-controlled barrel shifter. Each cycle it can accept one data-processing operation: a first operand Rn, a shifted second operand (the shifter's Rd output) and the shifter carry-out. It evaluates the ARM condition code against its internal NZCV register, computes the result and updates the flags when S is set. Results are handed to writeback through a one-entry registered output with a valid/ready handshake.

---
 rtl/alu_exec.sv | 192 +++++++++++++++++++
 tb/tb_alu_exec.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// Execute stage: ARM condition check, 32-bit ALU with NZCV flags and a one-entry valid/ready output register.
// Define ALU_EXEC_CARRY_OPS_EN to make ADC/SBC/RSC use the C flag; otherwise they act as ADD/SUB/RSB.
module alu_exec (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  cond,
    input  logic [3:0]  opcode,
    input  logic        s_bit,
    input  logic [31:0] rn_val,
    input  logic [31:0] op2,
    input  logic        shift_carry,
    input  logic [3:0]  rd_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        wb_en,
    output logic [3:0]  rd_out,
    output logic [3:0]  nzcv
);

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    logic        out_valid_r;
    logic [31:0] result_r;
    logic        wb_en_r;
    logic [3:0]  rd_out_r;
    logic [3:0]  nzcv_r;

    logic [31:0] op_a_s;
    logic [31:0] op_b_s;
    logic        cin_s;
    logic        is_arith_s;
    logic [31:0] logic_res_s;
    logic [32:0] sum_s;
    logic [31:0] alu_res_s;
    logic [3:0]  new_flags_s;
    logic        pass_s;
    logic        is_compare_s;
    logic        accept_s;

    // ARM condition table evaluated against the flags {N,Z,C,V}
    function automatic logic cond_pass(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, p;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'h0:    p = z;
            4'h1:    p = !z;
            4'h2:    p = c;
            4'h3:    p = !c;
            4'h4:    p = n;
            4'h5:    p = !n;
            4'h6:    p = v;
            4'h7:    p = !v;
            4'h8:    p = c && !z;
            4'h9:    p = !c || z;
            4'hA:    p = (n == v);
            4'hB:    p = (n != v);
            4'hC:    p = !z && (n == v);
            4'hD:    p = z || (n != v);
            4'hE:    p = 1'b1;
            default: p = 1'b0;
        endcase
        return p;
    endfunction

    // Operand selection, adder and logical unit
    always_comb begin
        op_a_s      = rn_val;
        op_b_s      = op2;
        cin_s       = 1'b0;
        is_arith_s  = 1'b0;
        logic_res_s = 32'h0000_0000;
        case (opcode)
            OP_ADD, OP_CMN: begin
                is_arith_s = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                is_arith_s = 1'b1;
                op_b_s     = ~op2;
                cin_s      = 1'b1;
            end
            OP_RSB: begin
                is_arith_s = 1'b1;
                op_a_s     = op2;
                op_b_s     = ~rn_val;
                cin_s      = 1'b1;
            end
`ifdef ALU_EXEC_CARRY_OPS_EN
            OP_ADC: begin
                is_arith_s = 1'b1;
                cin_s      = nzcv_r[1];
            end
            OP_SBC: begin
                is_arith_s = 1'b1;
                op_b_s     = ~op2;
                cin_s      = nzcv_r[1];
            end
            OP_RSC: begin
                is_arith_s = 1'b1;
                op_a_s     = op2;
                op_b_s     = ~rn_val;
                cin_s      = nzcv_r[1];
            end
`else
            OP_ADC: begin
                is_arith_s = 1'b1;
            end
            OP_SBC: begin
                is_arith_s = 1'b1;
                op_b_s     = ~op2;
                cin_s      = 1'b1;
            end
            OP_RSC: begin
                is_arith_s = 1'b1;
                op_a_s     = op2;
                op_b_s     = ~rn_val;
                cin_s      = 1'b1;
            end
`endif
            OP_AND, OP_TST: logic_res_s = rn_val & op2;
            OP_EOR, OP_TEQ: logic_res_s = rn_val ^ op2;
            OP_ORR:         logic_res_s = rn_val | op2;
            OP_MOV:         logic_res_s = op2;
            OP_BIC:         logic_res_s = rn_val & ~op2;
            OP_MVN:         logic_res_s = ~op2;
            default:        logic_res_s = 32'h0000_0000;
        endcase
        sum_s     = {1'b0, op_a_s} + {1'b0, op_b_s} + {32'h0000_0000, cin_s};
        alu_res_s = is_arith_s ? sum_s[31:0] : logic_res_s;
    end

    // Flag generation, condition pass and handshake qualifiers
    always_comb begin
        new_flags_s[3] = alu_res_s[31];
        new_flags_s[2] = (alu_res_s == 32'h0000_0000);
        new_flags_s[1] = is_arith_s ? sum_s[32] : shift_carry;
        new_flags_s[0] = is_arith_s ? ((op_a_s[31] == op_b_s[31]) && (sum_s[31] != op_a_s[31]))
                                    : nzcv_r[0];
        pass_s       = cond_pass(cond, nzcv_r);
        is_compare_s = (opcode[3:2] == 2'b10);
        in_ready     = !out_valid_r || out_ready;
        accept_s     = in_valid && in_ready;
    end

    // Output register and flag register; new accept overrides a same-cycle drain
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            result_r    <= 32'h0000_0000;
            wb_en_r     <= 1'b0;
            rd_out_r    <= 4'h0;
            nzcv_r      <= 4'h0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
            result_r    <= alu_res_s;
            wb_en_r     <= pass_s && !is_compare_s;
            rd_out_r    <= rd_addr;
            if (pass_s && s_bit) begin
                nzcv_r <= new_flags_s;
            end
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign wb_en     = wb_en_r;
    assign rd_out    = rd_out_r;
    assign nzcv      = nzcv_r;

endmodule

// File: tb/tb_alu_exec.sv
// Bench for alu_exec: directed scenarios plus randomized traffic against an arithmetic reference model.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        s_bit;
    logic [31:0] rn_val;
    logic [31:0] op2;
    logic        shift_carry;
    logic [3:0]  rd_addr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        wb_en;
    logic [3:0]  rd_out;
    logic [3:0]  nzcv;

    int checks   = 0;
    int failures = 0;

    logic        m_valid  = 1'b0;
    logic [31:0] m_result = 32'h0;
    logic        m_wb     = 1'b0;
    logic [3:0]  m_rd     = 4'h0;
    logic [3:0]  m_nzcv   = 4'h0;

    logic [31:0] edge_vals [4] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    always #5 clk = ~clk;

    alu_exec dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .opcode(opcode), .s_bit(s_bit), .rn_val(rn_val), .op2(op2),
        .shift_carry(shift_carry), .rd_addr(rd_addr), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .wb_en(wb_en), .rd_out(rd_out), .nzcv(nzcv)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v;
        {n, z, c, v} = f;
        case (cc)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {result, N, Z, C, V} computed with wide signed/unsigned integer arithmetic
    function automatic logic [35:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                            input logic sc, input logic [3:0] f);
        longint ua, ub, sa, sb, u, s, cf;
        logic [31:0] r;
        logic c, v, arith, is_sub;
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cf = f[1] ? 64'sd1 : 64'sd0;
        u = 64'sd0; s = 64'sd0; r = 32'h0;
        arith  = 1'b1;
        is_sub = op inside {4'h2, 4'h3, 4'h6, 4'h7, 4'hA};
        case (op)
            4'h4, 4'hB: begin u = ua + ub; s = sa + sb; end
            4'h2, 4'hA: begin u = ua - ub; s = sa - sb; end
            4'h3:       begin u = ub - ua; s = sb - sa; end
`ifdef ALU_EXEC_CARRY_OPS_EN
            4'h5: begin u = ua + ub + cf; s = sa + sb + cf; end
            4'h6: begin u = ua - ub - (64'sd1 - cf); s = sa - sb - (64'sd1 - cf); end
            4'h7: begin u = ub - ua - (64'sd1 - cf); s = sb - sa - (64'sd1 - cf); end
`else
            4'h5: begin u = ua + ub; s = sa + sb; end
            4'h6: begin u = ua - ub; s = sa - sb; end
            4'h7: begin u = ub - ua; s = sb - sa; end
`endif
            default: arith = 1'b0;
        endcase
        if (arith) begin
            r = u[31:0];
            c = is_sub ? (u >= 64'sd0) : (u >= 64'sd4294967296);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (op)
                4'h0, 4'h8: r = a & b;
                4'h1, 4'h9: r = a ^ b;
                4'hC:       r = a | b;
                4'hD:       r = b;
                4'hE:       r = a & ~b;
                default:    r = ~b;
            endcase
            c = sc;
            v = f[0];
        end
        return {r, r[31], r == 32'h0, c, v};
    endfunction

    task automatic drive(input logic iv, input logic [3:0] cd, input logic [3:0] op, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic sc, input logic [3:0] rd);
        in_valid = iv; cond = cd; opcode = op; s_bit = s;
        rn_val = a; op2 = b; shift_carry = sc; rd_addr = rd;
    endtask

    // One clock: predict from pre-edge inputs, advance the model, compare all outputs
    task automatic tick();
        logic acc, pass, rst, s, ordy;
        logic [3:0] op, rd;
        logic [35:0] r;
        #1;
        check_val("in_ready", {31'h0, in_ready}, {31'h0, (!m_valid || out_ready)});
        acc  = in_valid && (!m_valid || out_ready);
        pass = cond_ok(cond, m_nzcv);
        r    = ref_alu(opcode, rn_val, op2, shift_carry, m_nzcv);
        rst = reset; s = s_bit; ordy = out_ready; op = opcode; rd = rd_addr;
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 1'b0; m_result = 32'h0; m_wb = 1'b0; m_rd = 4'h0; m_nzcv = 4'h0;
        end else if (acc) begin
            m_valid  = 1'b1;
            m_result = r[35:4];
            m_wb     = pass && !(op inside {4'h8, 4'h9, 4'hA, 4'hB});
            m_rd     = rd;
            if (pass && s) m_nzcv = r[3:0];
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
        check_val("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
        check_val("nzcv", {28'h0, nzcv}, {28'h0, m_nzcv});
        check_val("result", result, m_result);
        check_val("wb_en", {31'h0, wb_en}, {31'h0, m_wb});
        check_val("rd_out", {28'h0, rd_out}, {28'h0, m_rd});
    endtask

    initial begin
        reset = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 4'hE, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 4'h0);
        tick();
        tick();
        check_val("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check_val("rst_nzcv", {28'h0, nzcv}, 32'h0);
        check_val("rst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;

        drive(1'b1, 4'hE, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h1);
        tick();
        check_val("adds_result", result, 32'h8000_0000);
        check_val("adds_wb", {31'h0, wb_en}, 32'h1);
        check_val("adds_nzcv", {28'h0, nzcv}, 32'h9);

        drive(1'b1, 4'hE, 4'hA, 1'b1, 32'h5, 32'h5, 1'b0, 4'h2);
        tick();
        check_val("cmp_wb", {31'h0, wb_en}, 32'h0);
        check_val("cmp_nzcv", {28'h0, nzcv}, 32'h6);
        drive(1'b1, 4'h0, 4'hD, 1'b0, 32'h0, 32'h12, 1'b0, 4'h3);
        tick();
        check_val("moveq_wb", {31'h0, wb_en}, 32'h1);
        check_val("moveq_result", result, 32'h12);
        drive(1'b1, 4'h1, 4'hD, 1'b0, 32'h0, 32'h34, 1'b0, 4'h4);
        tick();
        check_val("movne_wb", {31'h0, wb_en}, 32'h0);

        drive(1'b1, 4'hE, 4'h2, 1'b0, 32'h3, 32'h5, 1'b0, 4'h5);
        tick();
        check_val("sub_result", result, 32'hFFFF_FFFE);
        out_ready = 1'b0;
        drive(1'b1, 4'hE, 4'h4, 1'b0, 32'h1, 32'h1, 1'b0, 4'h6);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("stall_valid", {31'h0, out_valid}, 32'h1);
            check_val("stall_result", result, 32'hFFFF_FFFE);
            check_val("stall_in_ready", {31'h0, in_ready}, 32'h0);
        end
        out_ready = 1'b1;
        tick();
        check_val("after_stall_result", result, 32'h2);
        check_val("after_stall_rd", {28'h0, rd_out}, 32'h6);

        drive(1'b1, 4'hE, 4'hA, 1'b1, 32'h5, 32'h5, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'hE, 4'h5, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b0, 4'h7);
        tick();
`ifdef ALU_EXEC_CARRY_OPS_EN
        check_val("adc_result", result, 32'h0);
        check_val("adc_nzcv", {28'h0, nzcv}, 32'h6);
`else
        check_val("adc_result", result, 32'hFFFF_FFFF);
        check_val("adc_nzcv", {28'h0, nzcv}, 32'h8);
`endif

        drive(1'b1, 4'hE, 4'h4, 1'b1, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'hE, 4'h0, 1'b1, 32'hF0, 32'h0F, 1'b1, 4'h8);
        tick();
        check_val("ands_result", result, 32'h0);
        check_val("ands_nzcv", {28'h0, nzcv}, 32'h7);

        out_ready = 1'b0;
        drive(1'b1, 4'hE, 4'h4, 1'b1, 32'h1, 32'h1, 1'b0, 4'h9);
        tick();
        reset = 1'b1;
        tick();
        check_val("midrst_valid", {31'h0, out_valid}, 32'h0);
        check_val("midrst_nzcv", {28'h0, nzcv}, 32'h0);
        check_val("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        reset = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 600; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
            reset     = ($urandom_range(0, 79) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            drive($urandom_range(0, 4) != 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 1) == 1, a, b, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
